// File: rtl/router_egress_arbiter.sv
// Round-robin egress scheduler: picks one of three router output FIFOs,
// drains exactly one framed packet (header, len payload bytes, parity byte)
// onto the shared egress link, and aborts the packet if the granted FIFO
// starves for STALL_LIMIT consecutive cycles.
module router_egress_arbiter #(
  parameter int DATA_W      = 8,
  parameter int STALL_LIMIT = 32,
  parameter int CNT_W       = 6
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              vld_out_0,
  input  logic              vld_out_1,
  input  logic              vld_out_2,
  input  logic [DATA_W-1:0] dout0,
  input  logic [DATA_W-1:0] dout1,
  input  logic [DATA_W-1:0] dout2,
  input  logic              egress_ready,
  output logic              read_enb_0,
  output logic              read_enb_1,
  output logic              read_enb_2,
  output logic [DATA_W-1:0] egress_data,
  output logic              egress_valid,
  output logic              egress_sop,
  output logic              egress_eop,
  output logic [1:0]        egress_port,
  output logic              egress_abort,
  output logic              arb_busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HDR   = 3'd1;
  localparam logic [2:0] S_LEN   = 3'd2;
  localparam logic [2:0] S_BODY  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  localparam int SW = $clog2(STALL_LIMIT + 1);
  localparam logic [SW-1:0]    STALL_ONE  = SW'(1);
  localparam logic [SW-1:0]    STALL_LAST = SW'(STALL_LIMIT - 1);
  localparam logic [CNT_W:0]   REM_ONE    = (CNT_W + 1)'(1);

  logic [2:0]        state;
  logic [1:0]        grant;
  logic [1:0]        rr_ptr;
  logic [CNT_W:0]    remain;
  logic [SW-1:0]     stall_cnt;

  logic [2:0]        vld_vec;
  logic              vld_g;
  logic [DATA_W-1:0] dout_g;
  logic              any_vld;
  logic [1:0]        pick;
  logic [1:0]        cand1;
  logic [1:0]        cand2;
  logic              in_xfer;
  logic              issue;
  logic              stall_hit;

  function automatic logic [1:0] next_port(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Granted-port mux, round-robin candidate selection and read issue.
  always_comb begin
    vld_vec = {vld_out_2, vld_out_1, vld_out_0};
    any_vld = |vld_vec;
    vld_g   = vld_vec[grant];
    case (grant)
      2'd1:    dout_g = dout1;
      2'd2:    dout_g = dout2;
      default: dout_g = dout0;
    endcase
    cand1 = next_port(rr_ptr);
    cand2 = next_port(cand1);
    if (vld_vec[cand1])      pick = cand1;
    else if (vld_vec[cand2]) pick = cand2;
    else                     pick = rr_ptr;
    in_xfer   = (state == S_HDR) || (state == S_BODY);
    issue     = in_xfer && vld_g && egress_ready;
    stall_hit = in_xfer && !vld_g && (stall_cnt == STALL_LAST);
  end

  // Read strobes and link outputs; data is masked so an idle link reads zero.
  always_comb begin
    read_enb_0  = issue && (grant == 2'd0);
    read_enb_1  = issue && (grant == 2'd1);
    read_enb_2  = issue && (grant == 2'd2);
    egress_data = egress_valid ? dout_g : '0;
    egress_port = grant;
  end

  // Packet FSM, stall counter and registered egress framing flags.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= S_IDLE;
      grant        <= '0;
      rr_ptr       <= 2'd2;
      remain       <= '0;
      stall_cnt    <= '0;
      arb_busy     <= 1'b0;
      egress_valid <= 1'b0;
      egress_sop   <= 1'b0;
      egress_eop   <= 1'b0;
      egress_abort <= 1'b0;
    end else begin
      egress_valid <= issue;
      egress_sop   <= issue && (state == S_HDR);
      egress_eop   <= issue && (state == S_BODY) && (remain == REM_ONE);
      egress_abort <= 1'b0;
      if (stall_hit) begin
        egress_abort <= 1'b1;
        rr_ptr       <= grant;
        arb_busy     <= 1'b0;
        stall_cnt    <= '0;
        state        <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (any_vld) begin
              grant     <= pick;
              arb_busy  <= 1'b1;
              stall_cnt <= '0;
              state     <= S_HDR;
            end
          end
          S_HDR: begin
            if (issue) begin
              stall_cnt <= '0;
              state     <= S_LEN;
            end else if (!vld_g) begin
              stall_cnt <= stall_cnt + STALL_ONE;
            end
          end
          S_LEN: begin
            // Header is on dout_g now; one extra count covers the parity byte.
            remain    <= {1'b0, dout_g[2 +: CNT_W]} + REM_ONE;
            stall_cnt <= '0;
            state     <= S_BODY;
          end
          S_BODY: begin
            if (issue) begin
              stall_cnt <= '0;
              remain    <= remain - REM_ONE;
              if (remain == REM_ONE) state <= S_DRAIN;
            end else if (!vld_g) begin
              stall_cnt <= stall_cnt + STALL_ONE;
            end
          end
          S_DRAIN: begin
            rr_ptr   <= grant;
            arb_busy <= 1'b0;
            state    <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_router_egress_arbiter.sv
// Scoreboard bench for router_egress_arbiter: FIFO models feed the DUT,
// a packet-level round-robin model predicts the egress byte stream.
module tb_router_egress_arbiter;
  localparam int DATA_W = 8;
  localparam int STALL_LIMIT = 32;
  localparam int CNT_W = 6;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  logic vld_out_0 = 1'b0, vld_out_1 = 1'b0, vld_out_2 = 1'b0;
  logic [7:0] dout0 = '0, dout1 = '0, dout2 = '0;
  logic egress_ready = 1'b0;
  logic read_enb_0, read_enb_1, read_enb_2;
  logic [7:0] egress_data;
  logic egress_valid, egress_sop, egress_eop, egress_abort, arb_busy;
  logic [1:0] egress_port;

  always #5 clk = ~clk;

  router_egress_arbiter #(.DATA_W(DATA_W), .STALL_LIMIT(STALL_LIMIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .resetn(resetn),
    .vld_out_0(vld_out_0), .vld_out_1(vld_out_1), .vld_out_2(vld_out_2),
    .dout0(dout0), .dout1(dout1), .dout2(dout2),
    .egress_ready(egress_ready),
    .read_enb_0(read_enb_0), .read_enb_1(read_enb_1), .read_enb_2(read_enb_2),
    .egress_data(egress_data), .egress_valid(egress_valid),
    .egress_sop(egress_sop), .egress_eop(egress_eop),
    .egress_port(egress_port), .egress_abort(egress_abort), .arb_busy(arb_busy)
  );

  typedef struct {
    logic [7:0] data;
    bit         sop;
    bit         eop;
    logic [1:0] port;
    bit         abort;
  } exp_t;

  typedef struct {
    logic [1:0]  port;
    int unsigned base;
    int unsigned n;
    bit          trunc;
  } pkt_t;

  exp_t exp_q[$];
  pkt_t pend[$];
  logic [7:0] store[$];
  logic [7:0] fq0[$], fq1[$], fq2[$];

  int n_chk = 0;
  int n_pass = 0;
  int unsigned rr_m = 2;
  int rdy_mode = 0;
  int rd_cnt0 = 0, rd_cnt1 = 0, rd_cnt2 = 0;
  int n_out = 0;
  int n_abort = 0;
  bit gap_track = 1'b0;
  int low_run = 0;
  int gaps[$];
  exp_t mon_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  task automatic fifo_push(input int p, input logic [7:0] b);
    case (p)
      0: fq0.push_back(b);
      1: fq1.push_back(b);
      default: fq2.push_back(b);
    endcase
  endtask

  // keep < 0: full packet; keep >= 0: only header + keep payload bytes ever arrive.
  task automatic add_pkt(input int p, input int len, input int keep);
    pkt_t k;
    logic [5:0] l6;
    logic [7:0] hdr, b, par;
    int np;
    l6 = 6'(len);
    hdr = {l6, 2'($urandom)};
    k.port = 2'(p);
    k.base = store.size();
    k.trunc = (keep >= 0);
    store.push_back(hdr);
    fifo_push(p, hdr);
    par = hdr;
    np = k.trunc ? keep : len;
    for (int i = 0; i < np; i++) begin
      b = 8'($urandom);
      par = par ^ b;
      store.push_back(b);
      fifo_push(p, b);
    end
    if (!k.trunc) begin
      store.push_back(par);
      fifo_push(p, par);
    end
    k.n = store.size() - k.base;
    pend.push_back(k);
  endtask

  // Round-robin over pending packets: next port after the last served one.
  task automatic schedule();
    int idx;
    int unsigned cand;
    pkt_t k;
    exp_t e;
    while (pend.size() > 0) begin
      idx = -1;
      cand = rr_m;
      for (int s = 1; s <= 3; s++) begin
        if (idx < 0) begin
          for (int i = 0; i < pend.size(); i++) begin
            if (idx < 0 && pend[i].port == 2'((rr_m + s) % 3)) begin
              idx = i;
              cand = (rr_m + s) % 3;
            end
          end
        end
      end
      k = pend[idx];
      pend.delete(idx);
      for (int unsigned i = 0; i < k.n; i++) begin
        e.data = store[k.base + i];
        e.sop = (i == 0);
        e.eop = !k.trunc && (i == k.n - 1);
        e.port = k.port;
        e.abort = 1'b0;
        exp_q.push_back(e);
      end
      if (k.trunc) begin
        e.data = '0; e.sop = 0; e.eop = 0; e.port = k.port; e.abort = 1'b1;
        exp_q.push_back(e);
      end
      rr_m = cand;
    end
  endtask

  task automatic wait_idle(input string name, input int budget);
    int c;
    c = 0;
    while ((exp_q.size() != 0 || arb_busy) && c < budget) begin
      @(negedge clk);
      c++;
    end
    check({name, "_complete"}, 64'(c < budget), 64'd1);
  endtask

  task automatic wait_out(input int target, input int budget);
    int c;
    c = 0;
    while (n_out < target && c < budget) begin
      @(negedge clk);
      c++;
    end
    check("wait_out_bound", 64'(c < budget), 64'd1);
  endtask

  // FIFO models: pop on a sampled read strobe, data valid the next cycle.
  always @(posedge clk) begin
    if (resetn) begin
      if (read_enb_0) begin if (fq0.size() > 0) dout0 <= fq0.pop_front(); rd_cnt0++; end
      if (read_enb_1) begin if (fq1.size() > 0) dout1 <= fq1.pop_front(); rd_cnt1++; end
      if (read_enb_2) begin if (fq2.size() > 0) dout2 <= fq2.pop_front(); rd_cnt2++; end
    end
  end

  // Input drivers: FIFO non-empty flags and egress_ready pattern.
  always @(negedge clk) begin
    #1;
    vld_out_0 = (fq0.size() != 0);
    vld_out_1 = (fq1.size() != 0);
    vld_out_2 = (fq2.size() != 0);
    case (rdy_mode)
      0: egress_ready = 1'b1;
      1: egress_ready = ($urandom_range(3) != 0);
      default: egress_ready = 1'b0;
    endcase
  end

  // Read strobe legality, sampled just before the edge that acts on it.
  always @(negedge clk) begin
    #3;
    if (resetn && (read_enb_0 || read_enb_1 || read_enb_2)) begin
      check("read_onehot", 64'(int'(read_enb_0) + int'(read_enb_1) + int'(read_enb_2)), 64'd1);
      check("read_legal", 64'((!read_enb_0 || vld_out_0) && (!read_enb_1 || vld_out_1) &&
                              (!read_enb_2 || vld_out_2) && egress_ready), 64'd1);
    end
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (resetn) begin
      if (gap_track) begin
        if (!arb_busy) low_run++;
        else begin
          if (low_run != 0) gaps.push_back(low_run);
          low_run = 0;
        end
      end else low_run = 0;
      if (egress_abort) n_abort++;
      if (egress_valid || egress_abort) begin
        n_out++;
        n_chk++;
        if (exp_q.size() == 0) begin
          $display("FAIL egress_unexpected: got valid=%0b abort=%0b data=%02h port=%0d, required no output",
                   egress_valid, egress_abort, egress_data, egress_port);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.abort ? (egress_abort && !egress_valid)
                          : (egress_valid && !egress_abort && egress_data == mon_e.data &&
                             egress_sop == mon_e.sop && egress_eop == mon_e.eop &&
                             egress_port == mon_e.port))
            n_pass++;
          else
            $display("FAIL egress_item: got v=%0b d=%02h sop=%0b eop=%0b port=%0d abort=%0b, required d=%02h sop=%0b eop=%0b port=%0d abort=%0b",
                     egress_valid, egress_data, egress_sop, egress_eop, egress_port, egress_abort,
                     mon_e.data, mon_e.sop, mon_e.eop, mon_e.port, mon_e.abort);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, b1, b2, ab, gb, c, nrnd;
    logic [17:0] outs;
    #1 resetn = 1'b0;
    #2;
    outs = {read_enb_0, read_enb_1, read_enb_2, egress_data, egress_valid, egress_sop,
            egress_eop, egress_port, egress_abort, arb_busy};
    check("reset_outputs", 64'(outs), 64'd0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // Port 0 only, len=14: 16 reads, 16 egress bytes.
    b0 = rd_cnt0;
    add_pkt(0, 14, -1);
    schedule();
    wait_idle("t1", 500);
    check("t1_reads_port0", 64'(rd_cnt0 - b0), 64'd16);

    // Port 1 starves after 4 payload bytes; port 2 pending must follow the abort.
    ab = n_abort;
    add_pkt(1, 8, 4);
    add_pkt(2, 5, -1);
    schedule();
    wait_idle("abort", 1000);
    check("abort_pulses", 64'(n_abort - ab), 64'd1);

    // Three ports with len=3 plus a second port-0 packet: order 0,1,2,0.
    add_pkt(0, 3, -1); add_pkt(1, 3, -1); add_pkt(2, 3, -1); add_pkt(0, 3, -1);
    schedule();
    c = 0;
    while (!arb_busy && c < 50) begin @(posedge clk); #1; c++; end
    check("rr_grant_bound", 64'(c < 50), 64'd1);
    gb = gaps.size();
    gap_track = 1'b1;
    wait_idle("rr", 500);
    gap_track = 1'b0;
    check("rr_gap_count", 64'(gaps.size() - gb), 64'd3);
    for (int i = gb; i < gaps.size(); i++) check("rr_gap_len", 64'(gaps[i]), 64'd1);

    // egress_ready low for 3 cycles mid-payload of len=10.
    b1 = rd_cnt1;
    ab = n_abort;
    c = n_out;
    add_pkt(1, 10, -1);
    schedule();
    wait_out(c + 5, 200);
    rdy_mode = 2;
    repeat (3) @(negedge clk);
    rdy_mode = 0;
    wait_idle("ready_stall", 500);
    check("ready_stall_reads", 64'(rd_cnt1 - b1), 64'd12);
    check("ready_stall_no_abort", 64'(n_abort - ab), 64'd0);

    // Length boundaries on port 2 under random backpressure.
    rdy_mode = 1;
    b2 = rd_cnt2;
    add_pkt(2, 0, -1);
    add_pkt(2, 63, -1);
    schedule();
    wait_idle("len_bounds", 2000);
    check("len_bounds_reads", 64'(rd_cnt2 - b2), 64'd67);

    // Random batches.
    for (int r = 0; r < 6; r++) begin
      nrnd = 0;
      for (int p = 0; p < 3; p++) begin
        for (int k = 0; k < int'($urandom_range(2)); k++) begin
          add_pkt(p, int'($urandom_range(20)), -1);
          nrnd++;
        end
      end
      if (nrnd == 0) add_pkt(int'($urandom_range(2)), int'($urandom_range(20)), -1);
      schedule();
      wait_idle("random", 3000);
    end

    // Reset in the middle of a packet body.
    rdy_mode = 0;
    c = n_out;
    add_pkt(0, 40, -1);
    schedule();
    wait_out(c + 10, 200);
    @(posedge clk);
    #3 resetn = 1'b0;
    #1;
    outs = {read_enb_0, read_enb_1, read_enb_2, egress_data, egress_valid, egress_sop,
            egress_eop, egress_port, egress_abort, arb_busy};
    check("midreset_outputs", 64'(outs), 64'd0);
    exp_q.delete();
    pend.delete();
    fq0.delete(); fq1.delete(); fq2.delete();
    rr_m = 2;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    add_pkt(2, 2, -1);
    add_pkt(0, 3, -1);
    schedule();
    wait_idle("post_reset", 500);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
